// File: rtl/motor_bridge_driver.sv
`default_nettype none
// ============================================================================
// Module      : motor_bridge_driver
// Description : Multi-channel H-bridge driver. A shared free-running counter
//               produces PWM from a per-channel duty word; the PWM is steered
//               to In1 or In2 by the active direction. Every direction
//               reversal inserts a coast dead-time so a bridge leg is never
//               driven against itself.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_bridge_driver #(
    parameter int N_CH        = 2,
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 1000,
    parameter int DT_BITS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_CH*PWM_BITS-1:0] duty,
    input  logic [N_CH-1:0]          dir,
    output logic [2*N_CH-1:0]        out,
    output logic [N_CH-1:0]          busy
);

    // Per-channel FSM encoding
    localparam logic [0:0] c_st_drive = 1'b0;
    localparam logic [0:0] c_st_dead  = 1'b1;

    localparam logic [PWM_BITS-1:0] c_cnt_max = {PWM_BITS{1'b1}};
    localparam logic [DT_BITS-1:0]  c_dt_load = DT_BITS'(DEAD_CYCLES - 1);

    logic [PWM_BITS-1:0]            cnt_q, cnt_d;
    logic [N_CH-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [N_CH-1:0]                act_dir_q, act_dir_d;
    logic [N_CH-1:0][0:0]           state_q, state_d;
    logic [N_CH-1:0][DT_BITS-1:0]   dt_cnt_q, dt_cnt_d;
    logic [2*N_CH-1:0]              out_q, out_d;
    logic [N_CH-1:0]                busy_q, busy_d;
    logic [N_CH-1:0]                pwm;

    // Shared counter and period-aligned duty capture (new duty applies from cnt==0)
    always_comb begin
        cnt_d  = cnt_q + PWM_BITS'(1);
        duty_d = duty_q;
        if (cnt_q == c_cnt_max) begin
            for (int k = 0; k < N_CH; k++) begin
                duty_d[k] = duty[k*PWM_BITS +: PWM_BITS];
            end
        end
    end

    // Raw PWM per channel: high while the counter is below the captured duty
    always_comb begin
        pwm = '0;
        for (int k = 0; k < N_CH; k++) begin
            pwm[k] = (cnt_q < duty_q[k]);
        end
    end

    // Next-state logic: a direction mismatch starts a fixed-length coast;
    // the direction in force is adopted only when the coast expires
    always_comb begin
        state_d   = state_q;
        act_dir_d = act_dir_q;
        dt_cnt_d  = dt_cnt_q;
        for (int k = 0; k < N_CH; k++) begin
            case (state_q[k])
                c_st_drive: begin
                    if (dir[k] != act_dir_q[k]) begin
                        state_d[k]  = c_st_dead;
                        dt_cnt_d[k] = c_dt_load;
                    end
                end
                c_st_dead: begin
                    if (dt_cnt_q[k] == '0) begin
                        act_dir_d[k] = dir[k];
                        state_d[k]   = c_st_drive;
                    end else begin
                        dt_cnt_d[k] = dt_cnt_q[k] - DT_BITS'(1);
                    end
                end
            endcase
        end
    end

    // Output decode: drive only the leg matching the active direction, coast in DEAD
    always_comb begin
        out_d  = '0;
        busy_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (state_q[k] == c_st_drive) begin
                out_d[2*k]   = pwm[k] & ~act_dir_q[k] & enable;
                out_d[2*k+1] = pwm[k] &  act_dir_q[k] & enable;
            end else begin
                busy_d[k] = 1'b1;
            end
        end
    end

    // State register; reset overrides everything including an active coast
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            duty_q    <= '0;
            act_dir_q <= '0;
            state_q   <= {N_CH{c_st_drive}};
            dt_cnt_q  <= '0;
            out_q     <= '0;
            busy_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            act_dir_q <= act_dir_d;
            state_q   <= state_d;
            dt_cnt_q  <= dt_cnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_bridge_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_motor_bridge_driver
// Description : Directed scoreboard bench for motor_bridge_driver
//               (N_CH=2, PWM_BITS=4, DEAD_CYCLES=5, DT_BITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_bridge_driver;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] duty   = 8'h00;
    logic [1:0] dir    = 2'b00;
    logic [3:0] out;
    logic [1:0] busy;

    always #5 clk = ~clk;

    motor_bridge_driver #(
        .N_CH        (2),
        .PWM_BITS    (4),
        .DEAD_CYCLES (5),
        .DT_BITS     (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .duty   (duty),
        .dir    (dir),
        .out    (out),
        .busy   (busy)
    );

    typedef struct packed {
        logic [3:0] o;
        logic [1:0] b;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    int    errors = 0;
    int    checks = 0;
    string tag    = "reset";

    // Bench view of the period counter (value held before the next edge)
    // and the duty each channel is currently using.
    logic [3:0] tcnt = 4'd0;
    logic [3:0] teff [2];
    // Expected channel behaviour per step: 0 = drive fwd, 1 = drive rev, 2 = coast
    int         mode [2];

    // Compute the expectation for the coming edge, let the edge happen,
    // then hand the expectation to the monitor.
    task automatic step();
        exp_t e;
        logic p;
        e = '0;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                p = (tcnt < teff[k]) && enable;
                case (mode[k])
                    0:       e.o[2*k]   = p;
                    1:       e.o[2*k+1] = p;
                    default: e.b[k]     = 1'b1;
                endcase
            end
        end
        @(posedge clk);
        #1;
        sb.push_back(e);
        tq.push_back(tag);
        if (reset) begin
            tcnt    = 4'd0;
            teff[0] = 4'd0;
            teff[1] = 4'd0;
        end else begin
            if (tcnt == 4'd15) begin
                teff[0] = duty[3:0];
                teff[1] = duty[7:4];
            end
            tcnt = tcnt + 4'd1;
        end
    endtask

    task automatic run(input int n, input int m0, input int m1);
        mode[0] = m0;
        mode[1] = m1;
        repeat (n) step();
    endtask

    // Monitor: pops one expectation per cycle it is available, plus the
    // never-both-legs invariant every cycle.
    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tq.pop_front();
            checks++;
            if ({out, busy} !== {e.o, e.b}) begin
                errors++;
                $display("FAIL %s: out=%b busy=%b expected out=%b busy=%b at %0t",
                         t, out, busy, e.o, e.b, $time);
            end
        end
        checks++;
        if (((out[0] & out[1]) | (out[2] & out[3])) !== 1'b0) begin
            errors++;
            $display("FAIL shoot_through: out=%b expected no leg pair both high at %0t",
                     out, $time);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        teff[0] = 4'd0;
        teff[1] = 4'd0;

        // Reset state
        tag = "reset";
        run(2, 0, 0);
        reset = 1'b0;

        // 1: 50 % duty forward on ch0, ch1 at 3/16 forward
        enable = 1'b1;
        duty   = {4'd3, 4'd8};
        dir    = 2'b00;
        tag    = "t1_pwm";
        run(40, 0, 0);

        // 2: duty change mid-period only applies at the next period
        tag = "t2_sync_to_cnt3";
        while (tcnt != 4'd3) run(1, 0, 0);
        duty[3:0] = 4'd4;
        tag = "t2_duty_change";
        run(36, 0, 0);

        // 3: reversal on ch0: 5 coast clocks, then reverse leg; ch1 untouched
        dir[0] = 1'b1;
        tag = "t3_reverse";
        run(1, 0, 0);
        run(5, 2, 0);
        run(40, 1, 0);

        // back to forward before the toggle test
        dir[0] = 1'b0;
        tag = "t4_back_fwd";
        run(1, 1, 0);
        run(5, 2, 0);
        run(20, 0, 0);

        // 4: toggle away and back during coast: full dead-time, ends forward
        dir[0] = 1'b1;
        tag = "t4_toggle";
        run(1, 0, 0);
        run(2, 2, 0);
        dir[0] = 1'b0;
        run(3, 2, 0);
        run(20, 0, 0);

        // 5: reset in the middle of a coast, release forward at 15/16
        dir[0] = 1'b1;
        tag = "t5_enter_dead";
        run(1, 0, 0);
        run(2, 2, 0);
        reset     = 1'b1;
        dir[0]    = 1'b0;
        duty[3:0] = 4'd15;
        tag = "t5_reset_dead";
        run(2, 0, 0);
        reset = 1'b0;
        tag = "t5_duty15";
        run(40, 0, 0);

        // 6: duty 0 never drives
        duty[3:0] = 4'd0;
        tag = "t6_duty0";
        run(40, 0, 0);

        // enable drop while ch0 is high
        duty[3:0] = 4'd8;
        tag = "t6_sync";
        run(16, 0, 0);
        while (tcnt != 4'd2) run(1, 0, 0);
        enable = 1'b0;
        tag = "t6_enable_off";
        run(5, 0, 0);

        // reversal with drive disabled still takes the full coast
        dir[0] = 1'b1;
        tag = "t6_rev_disabled";
        run(1, 0, 0);
        run(5, 2, 0);
        run(20, 1, 0);
        enable = 1'b1;
        tag = "t6_rev_enabled";
        run(20, 1, 0);

        // drain the scoreboard
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
